// File: rtl/lcz80_io_pkg.sv
// Shared definitions for the lcz80 bus responders: register map, bit indices, FSM states.
package lcz80_io_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_VECTOR = 2'd3;

  localparam int unsigned STAT_RX_FULL  = 0;
  localparam int unsigned STAT_TX_VALID = 1;
  localparam int unsigned STAT_OVR      = 2;
  localparam int unsigned STAT_INT_REQ  = 3;

  localparam int unsigned CTRL_RX_INT_EN = 0;
  localparam int unsigned CTRL_TX_INT_EN = 1;

  localparam logic [7:0] VECTOR_RESET = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD
  } io_state_e;

endpackage

// File: rtl/lcz80_io_responder_if.sv
// CPU-side bus of the lcz80 core as seen by an I/O target.
interface lcz80_io_responder_if;
  logic        m1_n;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [15:0] A;
  logic [7:0]  di;
  logic [7:0]  dout;
  logic        dout_oe;
  logic        wait_n;
  logic        int_n;

  modport master (
    output m1_n, mreq_n, iorq_n, rd_n, wr_n, A, di,
    input  dout, dout_oe, wait_n, int_n
  );

  modport slave (
    input  m1_n, mreq_n, iorq_n, rd_n, wr_n, A, di,
    output dout, dout_oe, wait_n, int_n
  );
endinterface

// File: rtl/lcz80_wait_gen.sv
// Loadable down-counter: wait_n is low while the count is non-zero,
// done flags the clock on which the count reaches zero.
module lcz80_wait_gen #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic wait_n,
  output logic done
);
  localparam int unsigned W = $clog2(CYCLES + 2);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= W'(CYCLES);
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign wait_n = (cnt == '0);
  assign done   = (cnt == W'(1));
endmodule

// File: rtl/lcz80_io_responder.sv
// Z80 I/O target: four decoded ports, rx/tx byte mailboxes, wait insertion
// and IM2 interrupt acknowledge.
module lcz80_io_responder
  import lcz80_io_pkg::*;
#(
  parameter logic [7:0]  BASE_PORT   = 8'h40,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  lcz80_io_responder_if.slave         bus,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready
);
  io_state_e  state, state_d;
  logic [7:0] rx_buf;
  logic       rx_full;
  logic [1:0] ctrl;
  logic [7:0] vector;
  logic       ovr;
  logic [1:0] offset;
  logic       acc_rd;
  logic       int_req;
  logic [7:0] rd_mux;
  logic       io_hit, inta, bus_idle, decode, ack, wait_done;

  assign io_hit   = !bus.iorq_n && bus.m1_n && bus.mreq_n &&
                    (bus.A[7:2] == BASE_PORT[7:2]) && (!bus.rd_n || !bus.wr_n);
  assign inta     = !bus.m1_n && !bus.iorq_n;
  assign bus_idle = bus.rd_n && bus.wr_n && bus.iorq_n;
  assign decode   = (state == ST_IDLE) && io_hit;
  assign ack      = (state == ST_IDLE) && inta;

  assign int_req  = (rx_full && ctrl[CTRL_RX_INT_EN]) || (!tx_valid && ctrl[CTRL_TX_INT_EN]);
  assign rx_ready = !rx_full;

  lcz80_wait_gen #(.CYCLES(WAIT_CYCLES)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .load   (decode),
    .wait_n (bus.wait_n),
    .done   (wait_done)
  );

  always_comb begin
    rd_mux = '0;
    case (bus.A[1:0])
      REG_DATA:   rd_mux = rx_buf;
      REG_STATUS: rd_mux = {4'b0, int_req, ovr, tx_valid, rx_full};
      REG_CTRL:   rd_mux = {6'b0, ctrl};
      default:    rd_mux = vector;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (io_hit)
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_HOLD;
        else if (inta)
          state_d = ST_HOLD;
      end
      ST_WAIT: if (wait_done) state_d = ST_HOLD;
      ST_HOLD: if (bus_idle)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_buf      <= '0;
      rx_full     <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      ctrl        <= '0;
      vector      <= VECTOR_RESET;
      ovr         <= 1'b0;
      offset      <= '0;
      acc_rd      <= 1'b0;
      bus.dout    <= '0;
      bus.dout_oe <= 1'b0;
      bus.int_n   <= 1'b1;
    end else begin
      bus.int_n <= !int_req;

      if (tx_valid && tx_ready)
        tx_valid <= 1'b0;

      if (rx_valid && !rx_full) begin
        rx_buf  <= rx_data;
        rx_full <= 1'b1;
      end

      if (decode) begin
        offset <= bus.A[1:0];
        acc_rd <= bus.wr_n;
        if (!bus.wr_n) begin
          case (bus.A[1:0])
            // a handshake retiring this clock frees the buffer for the new byte
            REG_DATA: begin
              if (!tx_valid || tx_ready) begin
                tx_data  <= bus.di;
                tx_valid <= 1'b1;
              end else begin
                ovr <= 1'b1;
              end
            end
            REG_STATUS: if (bus.di[STAT_OVR]) ovr <= 1'b0;
            REG_CTRL:   ctrl   <= bus.di[1:0];
            default:    vector <= bus.di;
          endcase
        end else begin
          bus.dout    <= rd_mux;
          bus.dout_oe <= 1'b1;
        end
      end else if (ack) begin
        acc_rd      <= 1'b0;
        bus.dout    <= vector;
        bus.dout_oe <= 1'b1;
      end

      // rx byte is consumed only once the CPU has finished the DATA read
      if ((state == ST_HOLD) && bus_idle) begin
        bus.dout_oe <= 1'b0;
        if (acc_rd && (offset == REG_DATA))
          rx_full <= 1'b0;
      end
    end
  end
endmodule

// File: doc/lcz80_io_responder.md
Name: lcz80_io_responder

Overview:
- Z80 bus I/O responder: the target end of the bus cycles the lcz80 core initiates.
- Decodes IORQ read/write cycles to four ports and inserts programmable wait states.
- Provides a one-byte mailbox in each direction between the CPU and a host-side stream.
- Raises int_n and answers the interrupt-acknowledge cycle with an IM2 vector.
- Sits on the same clk as the CPU (cen tied 1); data/strobes come straight from the CPU pins.

Parameters:
- BASE_PORT, 8'h40, I/O base address; bits [1:0] must be 0.
- WAIT_CYCLES, 1, clocks wait_n is held low per decoded access (0 = none).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m1_n, mreq_n, iorq_n, rd_n, wr_n  in  1 each  CPU bus strobes.
- A  in  16  CPU address; only A[7:0] is decoded.
- di  in  8  CPU write data (CPU dout).
- dout  out  8  read data to CPU.
- dout_oe  out  1  high while this block drives dout.
- wait_n  out  1  wait request to CPU.
- int_n  out  1  interrupt request, active low.
- rx_data  in  8  host byte bound for the CPU.
- rx_valid  in  1  host byte valid.
- rx_ready  out  1  rx buffer empty; transfer happens when rx_valid & rx_ready.
- tx_data  out  8  CPU-written byte to host.
- tx_valid  out  1  tx buffer full.
- tx_ready  in  1  host accepts the byte; transfer happens when tx_valid & tx_ready.

Behaviour:
- Reset values: dout=0, dout_oe=0, wait_n=1, int_n=1, rx_ready=1, tx_valid=0, tx_data=0, ctrl=0, vector=8'hFF, ovr=0, FSM=IDLE.
- A reset mid-access aborts the access with no register side effect.
- Decode (io_hit): iorq_n=0 & m1_n=1 & A[7:2]==BASE_PORT[7:2] & (rd_n=0 | wr_n=0). mreq_n must be 1, otherwise no hit.
- Interrupt acknowledge (inta): m1_n=0 & iorq_n=0.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE->WAIT on io_hit when WAIT_CYCLES>0; IDLE->HOLD otherwise.
  - WAIT->HOLD when the wait counter reaches 0.
  - HOLD->IDLE when rd_n=1 & wr_n=1 & iorq_n=1.
  - inta is handled from IDLE->HOLD with no wait insertion.
- Decode cycle (IDLE with io_hit):
  - Latch the offset A[1:0] and direction.
  - On a write, capture di and apply the write.
  - On a read, register the read mux into dout.
  - Set dout_oe=1 from the next clock for reads and inta, held until HOLD exits.
- wait_n is low for exactly WAIT_CYCLES clocks, starting the clock after decode. The counter is loaded with WAIT_CYCLES at decode.
- Register map (offset from BASE_PORT):
  - 0 DATA
    - Write: if tx empty, load tx_data and set tx_valid. If tx full, drop the byte and set ovr.
    - Read: return the rx byte. rx_full clears at HOLD->IDLE, not at decode.
  - 1 STATUS
    - Read: {4'b0, int_req, ovr, tx_valid, rx_full}.
    - Write: 1 in bit 2 clears ovr; other bits ignored.
  - 2 CTRL (R/W): bit0 rx_int_en, bit1 tx_int_en; bits [7:2] read 0.
  - 3 VECTOR (R/W): IM2 vector.
- rx: rx_ready=~rx_full. The host transfer loads the byte and sets rx_full on the next clock.
- tx: tx_valid & tx_ready clears tx_valid.
  - If a CPU DATA write lands in the same clock as the tx handshake, the handshake retires first, the new byte is accepted and ovr is not set.
- Interrupts:
  - int_req = (rx_full & rx_int_en) | (~tx_valid & tx_int_en).
  - int_n = ~int_req, registered (1 clock latency), level-sensitive; cleared by servicing the cause.
  - inta drives dout=vector.
- Two back-to-back accesses need HOLD->IDLE in between; no pipelining.

Decomposition:
- Package lcz80_io_pkg holds:
  - Register offsets REG_DATA/REG_STATUS/REG_CTRL/REG_VECTOR.
  - STATUS/CTRL bit indices.
  - The FSM state enum.
  - The vector reset value 8'hFF.
- One natural sub-module, lcz80_wait_gen: a loadable down-counter producing wait_n and done. It is reused by the future memory-mapped responders.

Test Plan:
1. Reset then read STATUS at 8'h41 with WAIT_CYCLES=1 -> wait_n low 1 clock, dout=8'h00, dout_oe drops after rd_n/iorq_n rise.
2. Host sends 8'hA5 (rx_valid pulse), CTRL=8'h01 -> int_n low 1 clock later. Read DATA -> dout=8'hA5, then rx_ready=1 and int_n=1 after strobes release.
3. Write DATA=8'h3C with tx_ready=0, then write DATA=8'h77 -> tx_data stays 8'h3C and STATUS reads 8'h06. Write STATUS 8'h04 -> reads 8'h02.
4. Set VECTOR=8'h20, CTRL=8'h02 with tx empty, run an M1+IORQ acknowledge -> int_n low, dout=8'h20, dout_oe=1, wait_n stays 1.
5. Access port 8'h44 and a MREQ cycle at A=16'h0040 -> no dout_oe, wait_n=1, no register change.
6. Assert reset during the WAIT state of a DATA write -> wait_n=1, tx_valid=0, FSM IDLE next clock; the next access behaves normally.
